// File: rtl/cmip_bus_skid_pipe.sv
// cmip_bus_skid_pipe
// Valid/ready register pipeline built from STAGES registered skid stages.
// Data and valid travel forward, ready travels backward, and every one of
// them is registered at each stage, so no combinational path crosses the
// block. Each stage holds up to two beats (main + skid), which allows
// 1 beat/clk throughput even though ready is registered.
// STAGES = 0 degenerates to plain wires.
module cmip_bus_skid_pipe #(
  parameter int                   STAGES    = 2,
  parameter int                   DATA_WDTH = 8,
  parameter logic [DATA_WDTH-1:0] INIT_DATA = {DATA_WDTH{1'b0}},
  localparam int                  LVL_W     = (STAGES > 0) ? $clog2(2*STAGES+1) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_WDTH-1:0] i_din,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [DATA_WDTH-1:0] o_dout,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [LVL_W-1:0]     o_level
);

  // EMPTY: nothing held; ONE: main holds a beat; FULL: main and skid both hold beats
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  if (STAGES == 0) begin : g_wires
    assign o_dout  = i_din;
    assign o_valid = i_valid;
    assign o_ready = i_ready;
    assign o_level = '0;
  end else begin : g_pipe
    // Per-stage links: main valid / main data forward, ready backward
    logic [STAGES-1:0]           main_v_w;
    logic [STAGES-1:0]           rdy_w;
    logic [STAGES*DATA_WDTH-1:0] main_d_w;
    logic [LVL_W-1:0]            level_reg;
    logic [LVL_W-1:0]            level_next;
    logic                        in_hs;
    logic                        out_hs;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      stage_state_t         state_reg;
      stage_state_t         state_next;
      logic [DATA_WDTH-1:0] main_reg;
      logic [DATA_WDTH-1:0] main_next;
      logic [DATA_WDTH-1:0] skid_reg;
      logic [DATA_WDTH-1:0] skid_next;
      logic                 rdy_reg;
      logic                 rdy_next;
      logic                 up_valid;
      logic [DATA_WDTH-1:0] up_data;
      logic                 dn_ready;
      logic                 up_acc;
      logic                 pop;

      if (gi == 0) begin : g_src
        assign up_valid = i_valid;
        assign up_data  = i_din;
      end else begin : g_link
        assign up_valid = main_v_w[gi-1];
        assign up_data  = main_d_w[(gi-1)*DATA_WDTH +: DATA_WDTH];
      end

      if (gi == STAGES-1) begin : g_sink
        assign dn_ready = i_ready;
      end else begin : g_back
        assign dn_ready = rdy_w[gi+1];
      end

      assign up_acc = up_valid & rdy_reg;
      assign pop    = (state_reg != ST_EMPTY) & dn_ready;

      // Next-state and data movement; skid always drains into main before newer data
      always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
          ST_EMPTY: begin
            if (up_acc) begin
              main_next  = up_data;
              state_next = ST_ONE;
            end
          end
          ST_ONE: begin
            if (pop && up_acc) begin
              main_next = up_data;
            end else if (pop) begin
              state_next = ST_EMPTY;
            end else if (up_acc) begin
              skid_next  = up_data;
              state_next = ST_FULL;
            end
          end
          ST_FULL: begin
            if (pop) begin
              main_next  = skid_reg;
              state_next = ST_ONE;
            end
          end
          default: state_next = ST_EMPTY;
        endcase
        rdy_next = (state_next != ST_FULL);
      end

      // Stage registers; ready is low exactly while the skid is occupied
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          state_reg <= ST_EMPTY;
          main_reg  <= INIT_DATA;
          skid_reg  <= INIT_DATA;
          rdy_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          main_reg  <= main_next;
          skid_reg  <= skid_next;
          rdy_reg   <= rdy_next;
        end
      end

      assign main_v_w[gi]                          = (state_reg != ST_EMPTY);
      assign rdy_w[gi]                             = rdy_reg;
      assign main_d_w[gi*DATA_WDTH +: DATA_WDTH]   = main_reg;
    end

    assign o_valid = main_v_w[STAGES-1];
    assign o_dout  = main_d_w[(STAGES-1)*DATA_WDTH +: DATA_WDTH];
    assign o_ready = rdy_w[0];

    assign in_hs  = i_valid & o_ready;
    assign out_hs = o_valid & i_ready;

    // Occupancy follows the boundary handshakes; simultaneous in and out cancel
    always_comb begin
      level_next = level_reg;
      case ({in_hs, out_hs})
        2'b10:   level_next = level_reg + 1'b1;
        2'b01:   level_next = level_reg - 1'b1;
        default: level_next = level_reg;
      endcase
    end

    // Occupancy register
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        level_reg <= '0;
      end else begin
        level_reg <= level_next;
      end
    end

    assign o_level = level_reg;
  end

endmodule

// File: tb/tb_cmip_bus_skid_pipe.sv
// Bench for cmip_bus_skid_pipe (STAGES=2, DATA_WDTH=8, INIT_DATA=8'hA5).
// Directed phases drive the producer/consumer; a separate monitor keeps a
// scoreboard queue of accepted beats and checks every presented output.
module tb_cmip_bus_skid_pipe;

  logic       clk;
  logic       i_rst;
  logic [7:0] i_din;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_dout;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_level;

  int total = 0;
  int bad   = 0;
  int out_cnt = 0;
  bit mon_en = 0;
  bit prev_stall = 0;
  logic [7:0] prev_dout = 8'h00;
  logic [7:0] exp_q[$];

  cmip_bus_skid_pipe #(
    .STAGES   (2),
    .DATA_WDTH(8),
    .INIT_DATA(8'hA5)
  ) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_din  (i_din),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_dout (o_dout),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_level(o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard of accepted beats, sampled on the falling edge
  always @(negedge clk) begin
    if (!mon_en || i_rst) begin
      prev_stall = 0;
    end else begin
      check("level", 32'(o_level), 32'(exp_q.size()));
      if (prev_stall) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_dout", 32'(o_dout), 32'(prev_dout));
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%0h required=none t=%0t", o_dout, $time);
        end else begin
          check("dout", 32'(o_dout), 32'(exp_q[0]));
          if (i_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
          end
        end
      end
      if (i_valid && o_ready) exp_q.push_back(i_din);
      prev_stall = o_valid && !i_ready;
      prev_dout  = o_dout;
    end
  end

  // Producer that holds each beat until it is accepted
  task automatic run_producer(input int cycles, input logic [7:0] first, output int acc);
    bit hs;
    acc = 0;
    i_valid = 1'b1;
    i_din   = first;
    repeat (cycles) begin
      @(negedge clk);
      hs = o_ready;
      if (hs) acc++;
      @(posedge clk);
      #1;
      if (hs) i_din = i_din + 8'd1;
    end
  endtask

  // Drain everything with a bounded wait
  task automatic drain(input string name);
    int n;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((o_level != 3'd0 || o_valid) && n < 20);
    check(name, 32'(o_level), 32'd0);
  endtask

  initial begin
    int acc;
    bit hs;
    int n;
    i_rst   = 1'b1;
    i_din   = 8'h00;
    i_valid = 1'b0;
    i_ready = 1'b0;

    // 1: reset values, release, ready on first edge
    #3;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_dout", 32'(o_dout), 32'hA5);
    check("rst_level", 32'(o_level), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #7;
    i_rst = 1'b0;
    #1;
    check("rel_ready_before_edge", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_ready_first_edge", 32'(o_ready), 32'd1);
    mon_en = 1;

    // 2: streaming 0x00..0x0F with downstream always ready
    i_ready = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      i_valid = 1'b1;
      i_din   = 8'(i);
      @(negedge clk);
      check("stream_ready", 32'(o_ready), 32'd1);
      if (i < 2) check("stream_latency_valid", 32'(o_valid), 32'd0);
      if (i == 2) begin
        check("stream_first_valid", 32'(o_valid), 32'd1);
        check("stream_first_dout", 32'(o_dout), 32'h00);
      end
      if (i >= 2) check("stream_level", 32'(o_level), 32'd2);
    end
    drain("stream_drain");
    check("stream_count", 32'(out_cnt), 32'd16);

    // 3: stall fill, exactly four beats accepted
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    run_producer(8, 8'h10, acc);
    @(negedge clk);
    check("fill_accepted", 32'(acc), 32'd4);
    check("fill_ready", 32'(o_ready), 32'd0);
    check("fill_level", 32'(o_level), 32'd4);
    check("fill_dout", 32'(o_dout), 32'h10);
    check("fill_next_din", 32'(i_din), 32'h14);

    // 4: drain on consecutive clocks
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("drain_valid", 32'(o_valid), 32'd1);
      check("drain_dout", 32'(o_dout), 32'h10 + 32'(j));
      check("drain_level", 32'(o_level), 32'(4 - j));
    end
    @(negedge clk);
    check("drain_done_valid", 32'(o_valid), 32'd0);
    check("drain_done_level", 32'(o_level), 32'd0);
    check("drain_done_ready", 32'(o_ready), 32'd1);

    // 5: random valid/ready toggling, scoreboard checks every cycle
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      hs = i_valid && o_ready;
      @(posedge clk);
      #1;
      if (!i_valid || hs) begin
        i_valid = 1'($urandom_range(0, 1));
        i_din   = 8'($urandom);
      end
      i_ready = 1'($urandom_range(0, 1));
    end
    drain("random_drain");

    // 6: reset with three beats held, then no stale beat afterwards
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    run_producer(3, 8'h60, acc);
    i_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_level", 32'(o_level), 32'd3);
    #2;
    i_rst  = 1'b1;
    mon_en = 0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    check("mid_rst_dout", 32'(o_dout), 32'hA5);
    check("mid_rst_level", 32'(o_level), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst6_ready", 32'(o_ready), 32'd1);
    mon_en  = 1;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_din   = 8'h55;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_first", 32'(o_dout), 32'h55);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
